// File: rtl/counter_pkg.sv
// Shared mode encodings for the programmable tile counter.
package counter_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_UP_WRAP   = 2'b00;
  localparam mode_t MODE_DOWN_WRAP = 2'b01;
  localparam mode_t MODE_BOUNCE    = 2'b10;
  localparam mode_t MODE_UP_SAT    = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into ticks: one tick every prescale+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] psc;

  assign tick = en && (psc == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (clr) begin
      psc <= '0;
    end else if (en) begin
      psc <= (psc == prescale) ? '0 : psc + 1'b1;
    end
  end

endmodule

// File: rtl/multimode_counter.sv
// Programmable modulo counter: up-wrap, down-wrap, bounce and up-saturate modes
// with prescaler, synchronous load and a one-cycle terminal-count pulse.
module multimode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc
);

  logic             tick;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] load_count;
  logic             mode_dir;
  logic [WIDTH-1:0] next_count;
  logic             next_dir;
  logic             next_tc;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign count_inc  = count + 1'b1;
  assign count_dec  = count - 1'b1;
  assign load_count = (load_val > max_val) ? max_val : load_val;

  // Direction implied by the mode alone; bounce keeps whatever it has.
  always_comb begin
    mode_dir = 1'b1;
    case (mode)
      MODE_DOWN_WRAP: mode_dir = 1'b0;
      MODE_BOUNCE:    mode_dir = dir;
      default:        mode_dir = 1'b1;
    endcase
  end

  always_comb begin
    next_count = count;
    next_dir   = mode_dir;
    next_tc    = 1'b0;
    case (mode)
      MODE_UP_WRAP: begin
        if (count >= max_val) begin
          next_count = '0;
          next_tc    = 1'b1;
        end else begin
          next_count = count_inc;
        end
      end
      MODE_DOWN_WRAP: begin
        if (count == '0) begin
          next_count = max_val;
          next_tc    = 1'b1;
        end else if (count > max_val) begin
          next_count = max_val;
        end else begin
          next_count = count_dec;
        end
      end
      MODE_BOUNCE: begin
        if (dir && (count >= max_val)) begin
          next_dir   = 1'b0;
          next_count = (max_val == '0) ? '0 : max_val - 1'b1;
          next_tc    = 1'b1;
        end else if (!dir && (count == '0)) begin
          next_dir   = 1'b1;
          next_count = (max_val == '0) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
          next_tc    = 1'b1;
        end else begin
          next_count = dir ? count_inc : count_dec;
        end
      end
      MODE_UP_SAT: begin
        if (count < max_val) begin
          next_count = count_inc;
          next_tc    = (count_inc == max_val);
        end else begin
          next_count = max_val;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

  // Load outranks tick; a disabled counter keeps count and dir but drops tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= 1'b1;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_count;
      dir   <= (mode != MODE_DOWN_WRAP);
      tc    <= 1'b0;
    end else if (tick) begin
      count <= next_count;
      dir   <= next_dir;
      tc    <= next_tc;
    end else if (en) begin
      dir   <= mode_dir;
      tc    <= 1'b0;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// Directed and randomized checks of multimode_counter against an integer reference model.
module tb_multimode_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk      = 1'b0;
  logic                  rst_n    = 1'b1;
  logic                  en       = 1'b0;
  logic [1:0]            mode     = 2'b00;
  logic                  load     = 1'b0;
  logic [WIDTH-1:0]      load_val = '0;
  logic [WIDTH-1:0]      max_val  = '0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic [WIDTH-1:0]      count;
  logic                  dir;
  logic                  tc;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  int m_count;
  int m_dir;
  int m_tc;
  int m_psc;

  int p1_count[6] = '{1, 2, 3, 4, 5, 0};
  int p1_tc[6]    = '{0, 0, 0, 0, 0, 1};
  int p4_count[4] = '{3, 4, 4, 4};
  int p4_tc[4]    = '{0, 1, 0, 0};

  multimode_counter #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .prescale (prescale),
    .count    (count),
    .dir      (dir),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input int exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".count"}, 32'(count), m_count);
    checkValue({tag, ".dir"},   32'(dir),   m_dir);
    checkValue({tag, ".tc"},    32'(tc),    m_tc);
  endtask

  function automatic void model_reset();
    m_count = 0;
    m_dir   = 1;
    m_tc    = 0;
    m_psc   = 0;
  endfunction

  // What one rising edge does, computed from the counting rules on plain integers.
  function automatic void model_edge();
    int mx = int'(max_val);
    int c  = m_count;
    int m  = int'(mode);
    if (load) begin
      m_count = (int'(load_val) > mx) ? mx : int'(load_val);
      m_psc   = 0;
      m_tc    = 0;
      m_dir   = (m == 1) ? 0 : 1;
    end else if (!en) begin
      m_tc = 0;
    end else if (m_psc != int'(prescale)) begin
      m_psc = (m_psc + 1) % (1 << PRESCALE_W);
      m_tc  = 0;
      if (m != 2) m_dir = (m == 1) ? 0 : 1;
    end else begin
      m_psc = 0;
      m_tc  = 0;
      case (m)
        0: begin
          m_dir = 1;
          if (c >= mx) begin m_count = 0; m_tc = 1; end
          else m_count = c + 1;
        end
        1: begin
          m_dir = 0;
          if (c == 0) begin m_count = mx; m_tc = 1; end
          else if (c > mx) m_count = mx;
          else m_count = c - 1;
        end
        2: begin
          if (m_dir == 1 && c >= mx) begin
            m_dir = 0; m_count = (mx == 0) ? 0 : mx - 1; m_tc = 1;
          end else if (m_dir == 0 && c == 0) begin
            m_dir = 1; m_count = (mx == 0) ? 0 : 1; m_tc = 1;
          end else begin
            m_count = (m_dir == 1) ? c + 1 : c - 1;
          end
        end
        default: begin
          m_dir = 1;
          if (c < mx) begin m_count = c + 1; m_tc = (c + 1 == mx) ? 1 : 0; end
          else m_count = mx;
        end
      endcase
    end
  endfunction

  task automatic applyStimulus(input logic en_v, input logic [1:0] mode_v, input logic load_v,
                               input int load_val_v, input int max_v, input int presc_v,
                               input string tag);
    en       = en_v;
    mode     = mode_v;
    load     = load_v;
    load_val = WIDTH'(load_val_v);
    max_val  = WIDTH'(max_v);
    prescale = PRESCALE_W'(presc_v);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    checkValue("reset.count", 32'(count), 0);
    checkValue("reset.dir",   32'(dir),   1);
    checkValue("reset.tc",    32'(tc),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up-wrap through max_val=5, prescale 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 0, 5, 0, "upwrap");
      checkValue("upwrap.seq",    32'(count), p1_count[i]);
      checkValue("upwrap.tc_seq", 32'(tc),    p1_tc[i]);
    end

    // Down-wrap, max 3, tick every third cycle.
    applyStimulus(1'b1, 2'b01, 1'b1, 0, 3, 2, "down.load");
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b01, 1'b0, 0, 3, 2, "down");

    // Bounce between 0 and 3.
    applyStimulus(1'b1, 2'b10, 1'b1, 0, 3, 0, "bounce.load");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b10, 1'b0, 0, 3, 0, "bounce");

    // Up-saturate from a loaded 2, then max_val lowered below count.
    applyStimulus(1'b1, 2'b11, 1'b1, 2, 4, 0, "sat.load");
    checkValue("sat.load_val", 32'(count), 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 0, 4, 0, "sat");
      checkValue("sat.seq",    32'(count), p4_count[i]);
      checkValue("sat.tc_seq", 32'(tc),    p4_tc[i]);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 0, 2, 0, "sat.lower");
    checkValue("sat.lower_cnt", 32'(count), 2);
    checkValue("sat.lower_tc",  32'(tc),    0);

    // Up-wrap with max_val dropped under the count, then clamped load.
    applyStimulus(1'b1, 2'b00, 1'b1, 7, 9, 0, "lower.load");
    applyStimulus(1'b1, 2'b00, 1'b0, 0, 5, 0, "lower.tick");
    checkValue("lower.wrap_cnt", 32'(count), 0);
    checkValue("lower.wrap_tc",  32'(tc),    1);
    applyStimulus(1'b1, 2'b00, 1'b1, 9, 5, 0, "clamp");
    checkValue("clamp.cnt", 32'(count), 5);
    applyStimulus(1'b1, 2'b00, 1'b1, 9, 5, 0, "clamp.hold");

    // Asynchronous reset between edges, then a freeze with en low.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 0, 9, 1, "midrst.run");
    #2 rst_n = 1'b0;
    #1;
    checkValue("midrst.count", 32'(count), 0);
    checkValue("midrst.dir",   32'(dir),   1);
    checkValue("midrst.tc",    32'(tc),    0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 0, 9, 1, "freeze.pre");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 1'b0, 0, 9, 1, "freeze.off");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 1'b0, 0, 9, 1, "freeze.post");

    // Randomized traffic against the model.
    begin
      logic [1:0] r_mode = 2'b00;
      int r_max = 6;
      int r_psc = 0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 15) == 0) r_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0)
          r_max = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        if ($urandom_range(0, 29) == 0) r_psc = int'($urandom_range(0, 3));
        applyStimulus(($urandom_range(0, 9) != 0), r_mode, ($urandom_range(0, 24) == 0),
                      int'($urandom_range(0, 255)), r_max, r_psc, "random");
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
